// File: rtl/ysyx_2022040010_wb_stage.sv
// ysyx_2022040010_wb_stage: riscv64 writeback stage feeding the GPR regfile write port.
//   Two-entry buffer (head + skid) behind a valid/ready handshake from MEM; load data is
//   aligned and extended at capture time, so the regfile outputs come straight from head.
//   Ports: clk/rst (sync, active-high); wb_stall holds the head entry;
//   mem_* carries the incoming op, mem_ready = !skid valid;
//   rf_we/rf_waddr/rf_wdata write the regfile in the retire cycle; instret counts retires.
//   Optional macro YSYX_2022040010_DIFFTEST_EN adds commit_* outputs, registered one cycle after retire.
module ysyx_2022040010_wb_stage #(
   parameter int XLEN      = 64,
   parameter int INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_stall,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [XLEN-1:0]      mem_pc,
   input  logic [31:0]          mem_inst,
   input  logic                 mem_rd_we,
   input  logic [4:0]           mem_rd,
   input  logic [XLEN-1:0]      mem_alu_res,
   input  logic                 mem_is_load,
   input  logic [1:0]           mem_ld_size,
   input  logic                 mem_ld_unsigned,
   input  logic [2:0]           mem_ld_offset,
   input  logic [XLEN-1:0]      mem_rdata,
   output logic                 rf_we,
   output logic [4:0]           rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
`ifdef YSYX_2022040010_DIFFTEST_EN
   output logic                 commit_valid,
   output logic [XLEN-1:0]      commit_pc,
   output logic [31:0]          commit_inst,
   output logic                 commit_wen,
   output logic [4:0]           commit_wdest,
   output logic [XLEN-1:0]      commit_wdata,
`endif
   output logic [INSTRET_W-1:0] instret
);
   typedef struct packed {
      logic            v;
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            we;
      logic [4:0]      rd;
      logic [XLEN-1:0] res;
   } entry_t;
   entry_t head_q, head_d, skid_q, skid_d, in_e;
   logic [INSTRET_W-1:0] instret_q;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_w;
   logic [XLEN-1:0] ld_res;
   logic accept, retire;
   assign mem_ready = !skid_q.v;
   assign accept    = mem_valid && mem_ready;
   assign retire    = head_q.v && !wb_stall;
   assign ld_b = mem_rdata[{mem_ld_offset, 3'b000} +: 8];
   assign ld_h = mem_rdata[{mem_ld_offset[2:1], 4'b0000} +: 16];
   assign ld_w = mem_rdata[{mem_ld_offset[2], 5'b00000} +: 32];
   always_comb begin
      ld_res = mem_ld_size == 2'd0 ? {{(XLEN-8){!mem_ld_unsigned && ld_b[7]}}, ld_b} :
               mem_ld_size == 2'd1 ? {{(XLEN-16){!mem_ld_unsigned && ld_h[15]}}, ld_h} :
               mem_ld_size == 2'd2 ? {{(XLEN-32){!mem_ld_unsigned && ld_w[31]}}, ld_w} : mem_rdata;
      in_e = '{v: accept, pc: mem_pc, inst: mem_inst, we: mem_rd_we, rd: mem_rd,
               res: mem_is_load ? ld_res : mem_alu_res};
   end
   // Priority order keeps ops in sequence: a full skid always drains into head before new ops enter.
   always_comb begin
      head_d = head_q;
      skid_d = skid_q;
      if (retire && skid_q.v) begin
         head_d   = skid_q;
         skid_d.v = 1'b0;
      end else if (retire || !head_q.v) begin
         head_d = in_e;
      end else if (accept) begin
         skid_d = in_e;
      end
   end
   // Reset suppresses the write of an op retiring in the same cycle.
   assign rf_we    = retire && head_q.we && head_q.rd != 5'd0 && !rst;
   assign rf_waddr = head_q.rd;
   assign rf_wdata = head_q.res;
   assign instret  = instret_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q    <= '0;
         skid_q    <= '0;
         instret_q <= '0;
      end else begin
         head_q    <= head_d;
         skid_q    <= skid_d;
         instret_q <= instret_q + INSTRET_W'(retire);
      end
   end
`ifdef YSYX_2022040010_DIFFTEST_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         commit_valid <= 1'b0;
         commit_pc    <= '0;
         commit_inst  <= '0;
         commit_wen   <= 1'b0;
         commit_wdest <= '0;
         commit_wdata <= '0;
      end else begin
         commit_valid <= retire;
         if (retire) begin
            commit_pc    <= head_q.pc;
            commit_inst  <= head_q.inst;
            commit_wen   <= rf_we;
            commit_wdest <= head_q.rd;
            commit_wdata <= head_q.res;
         end
      end
   end
`endif
endmodule
